// File: rtl/gpu_pkg.sv
// Shared geometry-path types and constants for the vertex homogenizer.
// Provides the Q8.8 coordinate width, the W=1.0 constant, batch size and
// the packed vertex type {x,y,z}.
package gpu_pkg;

    localparam int COORD_W       = 16;
    localparam int VTX_PER_BATCH = 4;

    // Q8.8 representation of 1.0, used for the homogeneous W row.
    localparam logic signed [COORD_W-1:0] W_ONE = 16'sh0100;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vertex_t;

endpackage

// File: rtl/vtx_bank.sv
// One batch bank: 4 columns of {x,y,z} plus the real-vertex count.
// Ports: clk/rst (sync active-low clear), wr_en/wr_idx/close/vtx write side,
//        col[]/count read side (plain registers, no read latency).
module vtx_bank
    import gpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_idx,
    input  logic        close,
    input  vertex_t     vtx,
    output vertex_t     col [VTX_PER_BATCH],
    output logic [2:0]  count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < VTX_PER_BATCH; c++) begin
                col[c] <= '0;
            end
            count <= '0;
        end else if (wr_en) begin
            // The closing vertex is replicated into every remaining column so
            // padded primitives are degenerate rather than garbage.
            for (int c = 0; c < VTX_PER_BATCH; c++) begin
                if (c == int'(wr_idx) || (close && c > int'(wr_idx))) begin
                    col[c] <= vtx;
                end
            end
            if (close) begin
                count <= {1'b0, wr_idx} + 3'd1;
            end
        end
    end

endmodule

// File: rtl/vertex_homogenizer.sv
// Packs a serial (X,Y,Z) stream into column-major 4x4 homogeneous blocks
// (row 4 = W = 1.0) using a ping-pong pair of vtx_bank instances.
// Ports: CLK/rst (sync active-low), in_* vertex input with in_ready,
//        out_valid/out_ready block handshake, out_count, d11..d44 (dRC).
module vertex_homogenizer
    import gpu_pkg::*;
#(
    parameter int                        COORD_W = 16,
    parameter logic signed [COORD_W-1:0] W_ONE   = 16'sh0100
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] in_x,
    input  logic signed [COORD_W-1:0] in_y,
    input  logic signed [COORD_W-1:0] in_z,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_count,
    output logic signed [COORD_W-1:0] d11, d12, d13, d14,
    output logic signed [COORD_W-1:0] d21, d22, d23, d24,
    output logic signed [COORD_W-1:0] d31, d32, d33, d34,
    output logic signed [COORD_W-1:0] d41, d42, d43, d44
);

    logic        wr_bank;
    logic        rd_bank;
    logic [1:0]  wr_idx;
    logic [1:0]  full;

    logic        accept;
    logic        close;
    logic        pop;
    vertex_t     vtx;

    vertex_t     col0 [VTX_PER_BATCH];
    vertex_t     col1 [VTX_PER_BATCH];
    logic [2:0]  cnt0;
    logic [2:0]  cnt1;

    // Last presented block, so the outputs stay put while nothing is valid
    // even after the presented bank has been reused for new input.
    vertex_t     hold_col [VTX_PER_BATCH];
    logic [2:0]  hold_cnt;
    logic signed [COORD_W-1:0] hold_w;

    vertex_t     show [VTX_PER_BATCH];
    logic signed [COORD_W-1:0] w_out;

    // in_ready depends only on the registered full flag, so a bank being
    // presented can never be overwritten and out_ready has no path here.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign accept    = in_valid && in_ready;
    assign close     = accept && (wr_idx == 2'd3 || in_last);
    assign pop       = out_valid && out_ready;
    assign vtx       = '{x: in_x, y: in_y, z: in_z};

    vtx_bank u_bank0 (
        .clk    (CLK),
        .rst    (rst),
        .wr_en  (accept && !wr_bank),
        .wr_idx (wr_idx),
        .close  (close),
        .vtx    (vtx),
        .col    (col0),
        .count  (cnt0)
    );

    vtx_bank u_bank1 (
        .clk    (CLK),
        .rst    (rst),
        .wr_en  (accept && wr_bank),
        .wr_idx (wr_idx),
        .close  (close),
        .vtx    (vtx),
        .col    (col1),
        .count  (cnt1)
    );

    // Close targets wr_bank (not full) and pop targets rd_bank (full), so the
    // two never touch the same flag bit in one cycle.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= 2'd0;
            full    <= 2'b00;
        end else begin
            if (accept) begin
                if (close) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                    wr_idx        <= 2'd0;
                end else begin
                    wr_idx <= wr_idx + 2'd1;
                end
            end
            if (pop) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= !rd_bank;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            for (int c = 0; c < VTX_PER_BATCH; c++) begin
                hold_col[c] <= '0;
            end
            hold_cnt <= '0;
            hold_w   <= '0;
        end else begin
            if (out_valid) begin
                for (int c = 0; c < VTX_PER_BATCH; c++) begin
                    hold_col[c] <= rd_bank ? col1[c] : col0[c];
                end
                hold_cnt <= rd_bank ? cnt1 : cnt0;
            end
            if (accept) begin
                hold_w <= W_ONE;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < VTX_PER_BATCH; c++) begin
            show[c] = hold_col[c];
            if (out_valid) begin
                show[c] = rd_bank ? col1[c] : col0[c];
            end
        end
        out_count = hold_cnt;
        w_out     = hold_w;
        if (out_valid) begin
            out_count = rd_bank ? cnt1 : cnt0;
            w_out     = W_ONE;
        end
    end

    assign d11 = show[0].x;
    assign d12 = show[1].x;
    assign d13 = show[2].x;
    assign d14 = show[3].x;
    assign d21 = show[0].y;
    assign d22 = show[1].y;
    assign d23 = show[2].y;
    assign d24 = show[3].y;
    assign d31 = show[0].z;
    assign d32 = show[1].z;
    assign d33 = show[2].z;
    assign d34 = show[3].z;
    assign d41 = w_out;
    assign d42 = w_out;
    assign d43 = w_out;
    assign d44 = w_out;

endmodule

// File: tb/tb_vertex_homogenizer.sv
// Directed bench for vertex_homogenizer: reset, full/partial batches,
// backpressure with both banks full, streaming, mid-batch reset, extremes.
module tb_vertex_homogenizer;

    logic               CLK = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_x = '0;
    logic signed [15:0] in_y = '0;
    logic signed [15:0] in_z = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2:0]         out_count;
    logic signed [15:0] d11, d12, d13, d14, d21, d22, d23, d24;
    logic signed [15:0] d31, d32, d33, d34, d41, d42, d43, d44;

    int tests  = 0;
    int failed = 0;

    vertex_homogenizer dut (
        .CLK(CLK), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .d11(d11), .d12(d12), .d13(d13), .d14(d14),
        .d21(d21), .d22(d22), .d23(d23), .d24(d24),
        .d31(d31), .d32(d32), .d33(d33), .d34(d34),
        .d41(d41), .d42(d42), .d43(d43), .d44(d44)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int d_at(input int r, input int c);
        case (r * 10 + c)
            11: return int'(d11);  12: return int'(d12);
            13: return int'(d13);  14: return int'(d14);
            21: return int'(d21);  22: return int'(d22);
            23: return int'(d23);  24: return int'(d24);
            31: return int'(d31);  32: return int'(d32);
            33: return int'(d33);  34: return int'(d34);
            41: return int'(d41);  42: return int'(d42);
            43: return int'(d43);  44: return int'(d44);
            default: return 32'h7fff_ffff;
        endcase
    endfunction

    // Check one column: X/Y/Z plus W == 1.0 (Q8.8 256).
    task automatic chk_col(input string tag, input int c, input int x, input int y, input int z);
        chk($sformatf("%s_c%0d_x", tag, c), d_at(1, c), x);
        chk($sformatf("%s_c%0d_y", tag, c), d_at(2, c), y);
        chk($sformatf("%s_c%0d_z", tag, c), d_at(3, c), z);
        chk($sformatf("%s_c%0d_w", tag, c), d_at(4, c), 256);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int x, input int y, input int z, input bit last);
        in_valid = 1'b1;
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_z     = 16'(z);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    int accepted;
    int held_d11;
    int held_d34;

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_d11", int'(d11), 0);
        chk("rst_d44", int'(d44), 0);
        rst = 1'b1;
        tick();

        // Full batch of 4, consumer ready
        out_ready = 1'b1;
        send(1, 2, 3, 1'b0);
        chk("b1_valid_early", int'(out_valid), 0);
        send(4, 5, 6, 1'b0);
        send(7, 8, 9, 1'b0);
        send(-1, -2, -3, 1'b0);
        chk("b1_out_valid", int'(out_valid), 1);
        chk("b1_count", int'(out_count), 4);
        chk_col("b1", 1, 1, 2, 3);
        chk_col("b1", 2, 4, 5, 6);
        chk_col("b1", 3, 7, 8, 9);
        chk_col("b1", 4, -1, -2, -3);
        tick();
        chk("b1_popped", int'(out_valid), 0);
        chk("b1_hold_d14", int'(d14), -1);

        // Two vertices closed by in_last: columns 3/4 padded with vertex 2
        send(10, 20, 30, 1'b0);
        send(40, 50, 60, 1'b1);
        chk("b2_out_valid", int'(out_valid), 1);
        chk("b2_count", int'(out_count), 2);
        chk_col("b2", 1, 10, 20, 30);
        chk_col("b2", 2, 40, 50, 60);
        chk_col("b2", 3, 40, 50, 60);
        chk_col("b2", 4, 40, 50, 60);
        tick();
        chk("b2_popped", int'(out_valid), 0);

        // Backpressure: 12 offered, only 8 fit in the two banks
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) accepted++;
            in_valid = 1'b1;
            in_x = 16'(100 + i);
            in_y = 16'(200 + i);
            in_z = 16'(300 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", accepted, 8);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        chk_col("bp_blk0", 1, 100, 200, 300);
        chk_col("bp_blk0", 4, 103, 203, 303);
        held_d11 = int'(d11);
        held_d34 = int'(d34);
        tick();
        tick();
        tick();
        chk("bp_stall_d11", int'(d11), held_d11);
        chk("bp_stall_d34", int'(d34), held_d34);
        chk("bp_stall_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_after_pop", int'(in_ready), 1);
        chk("bp_blk1_valid", int'(out_valid), 1);
        chk("bp_blk1_count", int'(out_count), 4);
        chk_col("bp_blk1", 1, 104, 204, 304);
        chk_col("bp_blk1", 4, 107, 207, 307);
        out_ready = 1'b1;
        tick();
        chk("bp_drained", int'(out_valid), 0);

        // Continuous stream of 16 with out_ready high
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("st_in_ready_%0d", i), int'(in_ready), 1);
            send(i, -i, 2 * i, 1'b0);
            if (i % 4 == 3) begin
                chk($sformatf("st_valid_%0d", i), int'(out_valid), 1);
                chk($sformatf("st_d11_%0d", i), int'(d11), i - 3);
                chk($sformatf("st_d24_%0d", i), int'(d24), -i);
                chk($sformatf("st_d34_%0d", i), int'(d34), 2 * i);
            end else begin
                chk($sformatf("st_nvalid_%0d", i), int'(out_valid), 0);
            end
        end
        tick();
        chk("st_end_valid", int'(out_valid), 0);

        // Reset with one bank full and the other half-filled
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(50 + i, 60 + i, 70 + i, 1'b0);
        end
        chk("mr_pre_valid", int'(out_valid), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_out_count", int'(out_count), 0);
        chk("mr_d11", int'(d11), 0);
        chk("mr_d23", int'(d23), 0);
        chk("mr_d34", int'(d34), 0);
        chk("mr_d41", int'(d41), 0);
        chk("mr_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        send(11, 12, 13, 1'b0);
        send(21, 22, 23, 1'b0);
        send(31, 32, 33, 1'b0);
        send(41, 42, 43, 1'b0);
        chk("mr_new_valid", int'(out_valid), 1);
        chk("mr_new_count", int'(out_count), 4);
        chk_col("mr_new", 1, 11, 12, 13);
        chk_col("mr_new", 2, 21, 22, 23);
        chk_col("mr_new", 3, 31, 32, 33);
        chk_col("mr_new", 4, 41, 42, 43);
        tick();
        chk("mr_new_popped", int'(out_valid), 0);

        // Single extreme vertex replicated across all columns
        send(-32768, 32767, 0, 1'b1);
        chk("sg_valid", int'(out_valid), 1);
        chk("sg_count", int'(out_count), 1);
        for (int c = 1; c <= 4; c++) begin
            chk_col("sg", c, -32768, 32767, 0);
        end
        tick();
        chk("sg_popped", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vertex_homogenizer.md
Name: vertex_homogenizer

Overview:
Packs a serial stream of 3-D vertices into the 4x4 homogeneous block consumed by the normalization stage. The matrix block is column-major: column C is vertex C, row 1/2/3/4 = X/Y/Z/W, and W is the fixed-point constant 1.0. It sits between the vertex fetch stage and the transform/normalization path. It is the inverse of the perspective divide: it promotes (X,Y,Z) to (X,Y,Z,1) and groups 4 vertices per batch. A ping-pong bank pair lets input fill one batch while the other waits for the downstream consumer.

Parameters:
COORD_W, 16, width of every signed coordinate (Q8.8).
W_ONE, 16'sh0100, value driven on row 4 (W) for every column, including padded columns.

Ports:
CLK  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-low reset.
in_valid  input  1  input vertex valid.
in_ready  output  1  block can accept a vertex this cycle.
in_x, in_y, in_z  input  COORD_W each  signed vertex coordinates.
in_last  input  1  closes the current batch after this vertex; unused columns are padded.
out_valid  output  1  a complete 4x4 block is presented.
out_ready  input  1  the consumer takes the block this cycle.
out_count  output  3  number of real vertices in the presented block (1..4).
d11..d44  output  COORD_W each  signed matrix; dRC = row R, column C.

Behaviour:
- Reset (rst==0 at a clock edge):
  - both banks are zeroed; outputs d11..d44 = 0.
  - out_count = 0, out_valid = 0, wr_bank = rd_bank = 0, wr_idx = 0, both full flags = 0.
  - Reset mid-batch discards all partial and full batches with no output.
- in_ready = !full[wr_bank], driven from registered state only; it has no combinational path from out_ready.
- Accept: when in_valid && in_ready, X/Y/Z are written into column wr_idx+1 of bank wr_bank.
- Batch close: the batch closes when wr_idx==3 or in_last==1. In that same cycle:
  - columns wr_idx+1..4 all receive this vertex (replicated padding, which gives degenerate primitives and no divide-by-zero downstream);
  - count[wr_bank] = wr_idx+1;
  - full[wr_bank] = 1;
  - wr_bank toggles and wr_idx = 0.
- No close: otherwise wr_idx increments.
- in_last with wr_idx==3 is identical to a normal close.
- Row 4 (d41..d44) is always W_ONE whenever out_valid==1.
- Output side:
  - out_valid = full[rd_bank].
  - d11..d34 and out_count are driven from the bank rd_bank registers.
  - They hold stable while out_valid && !out_ready.
  - While out_valid==0, d/out_count hold the last presented values (0 after reset). W rows read 0 after reset, then W_ONE once a bank has been written.
- Pop: when out_valid && out_ready, full[rd_bank] is cleared and rd_bank toggles.
- Latency: the closing vertex accepted at edge t gives out_valid=1 after edge t, provided full[rd_bank] was clear. Otherwise the block is presented the cycle after the prior block pops.
- Throughput: 1 vertex/cycle sustained when out_ready is held high; in_ready never drops in that case.
- Simultaneous close (bank A) and pop (bank B) in one cycle: both take effect.
- Bank collision is impossible because in_ready uses the registered full flag.
- Backpressure: with both banks full, in_ready=0. Input is stalled until a pop, and in_ready rises the cycle after the pop.
- Arithmetic: none beyond the 2-bit wr_idx and the 3-bit count. Coordinates pass through bit-exact, with no saturation or sign change.

Decomposition:
- Shared package gpu_pkg: COORD_W, W_ONE (Q8.8 one), VTX_PER_BATCH=4, and a vertex typedef {x,y,z} of signed COORD_W.
- One sub-module, vtx_bank, instantiated twice. It holds:
  - a 4-column by 3-component register file;
  - column write with pad-to-end;
  - the count register;
  - synchronous active-low clear.
- Control (wr_bank, wr_idx, rd_bank, full flags) stays in the top.

Test Plan:
- Reset then 4 vertices (1,2,3), (4,5,6), (7,8,9), (-1,-2,-3) in 4 consecutive cycles with out_ready=1 -> out_valid=1 the cycle after the 4th. Expect d11..d14=1,4,7,-1; d21..d24=2,5,8,-2; d31..d34=3,6,9,-3; d41..d44=16'h0100; out_count=4; out_valid=0 after the pop.
- 2 vertices (10,20,30), (40,50,60) with in_last on the 2nd -> columns 3 and 4 equal (40,50,60); out_count=2; W row all 16'h0100.
- out_ready=0 with 12 vertices offered back-to-back:
  - 8 are accepted, then in_ready=0;
  - d values stay constant while stalled;
  - raising out_ready for 1 cycle raises in_ready on the next cycle, and the second block is presented immediately after.
- Continuous stream of 16 vertices with out_ready=1 -> in_ready never low; 4 blocks in order; each out_valid pulse lasts exactly 1 cycle.
- Reset asserted after 3 vertices of a batch with the other bank full -> out_valid=0, all d=0, out_count=0 on the following cycle. A fresh 4-vertex batch then produces only its own data.
- Single vertex (-32768,32767,0) with in_last -> all 4 columns carry it exactly; out_count=1.
